// File: rtl/neopix_tx_if.sv
// Byte stream from the SPI receive slave into the NeoPixel transmitter.
// The master side owns the byte and its one-cycle write strobe.
interface neopix_tx_if;
    logic [7:0] data_in;
    logic       data_valid;

    modport master (
        output data_in,
        output data_valid
    );

    modport slave (
        input data_in,
        input data_valid
    );
endinterface

// File: rtl/neopix_tx.sv
// WS2812 serializer: buffers incoming bytes in a small FIFO and shifts them
// out MSB-first with cycle-counted high/low times. When the FIFO runs dry a
// latch period (continuous low) is driven so the LED chain updates.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_LATCH | dout low for TRESET cycles, then frame_done pulse; reset state
// S_IDLE  | dout low, waiting for a byte in the FIFO
// S_BIT   | serializing shreg[7]; each bit lasts TBIT cycles
module neopix_tx #(
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int TBIT       = 63,
    parameter int TRESET     = 3000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    neopix_tx_if.slave                  bus,
    output logic                        dout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        frame_done
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (TRESET > TBIT) ? TRESET : TBIT;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] BIT_LAST   = CW'(TBIT - 1);
    localparam logic [CW-1:0] RESET_LAST = CW'(TRESET - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_LATCH,
        S_IDLE,
        S_BIT
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_FULL);
    assign push       = bus.data_valid && !fifo_full;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    // Storage array: written on accepted pushes, no reset needed since the
    // pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy; a push and a pop in the same cycle cancel
    // in the level count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag: a strobe while full loses the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (bus.data_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bitidx;
    logic [2:0]    bitidx_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          dout_nxt;
    logic          frame_done_nxt;

    // State and datapath registers; dout and frame_done are registered so
    // the line is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LATCH;
            cnt        <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bitidx     <= bitidx_nxt;
            shreg      <= shreg_nxt;
            dout       <= dout_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state, counter, shift and pop decisions.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bitidx_nxt     = bitidx;
        shreg_nxt      = shreg;
        dout_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        pop            = 1'b0;

        case (state)
            S_LATCH: begin
                // Runs to completion even if bytes arrive meanwhile.
                if (cnt == RESET_LAST) begin
                    frame_done_nxt = 1'b1;
                    cnt_nxt        = '0;
                    state_nxt      = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_nxt  = head;
                    bitidx_nxt = 3'd7;
                    cnt_nxt    = '0;
                    state_nxt  = S_BIT;
                end
            end

            S_BIT: begin
                dout_nxt = (cnt < (shreg[7] ? T1H_C : T0H_C));
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (bitidx != 3'd0) begin
                        shreg_nxt  = {shreg[6:0], 1'b0};
                        bitidx_nxt = bitidx - 3'd1;
                    end else if (!fifo_empty) begin
                        // Back-to-back byte: reload with no gap cycle.
                        pop        = 1'b1;
                        shreg_nxt  = head;
                        bitidx_nxt = 3'd7;
                    end else begin
                        state_nxt = S_LATCH;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = S_LATCH;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_neopix_tx.sv
// Directed bench for neopix_tx: measures every bit's high time and period
// on dout, frame_done timing, FIFO level and overflow behaviour.
module tb_neopix_tx;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TRESET = 3000;
    localparam int DEPTH  = 16;

    logic       clk;
    logic       reset;
    logic       dout;
    logic       busy;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       frame_done;

    neopix_tx_if bus_if ();

    neopix_tx #(
        .T0H        (T0H),
        .T1H        (T1H),
        .TBIT       (TBIT),
        .TRESET     (TRESET),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .dout       (dout),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line monitor state, all owned by the main initial block.
    int   smp;
    logic dout_prev;
    int   last_rise;
    int   first_rise;
    int   hi_q[$];
    int   per_q[$];
    int   fd_cnt;
    int   fd_at;
    int   fd_from_rise;
    int   lvl_max;

    task automatic arm();
        smp          = 0;
        dout_prev    = dout;
        last_rise    = 0;
        first_rise   = -1;
        hi_q.delete();
        per_q.delete();
        fd_cnt       = 0;
        fd_at        = -1;
        fd_from_rise = -1;
        lvl_max      = int'(fifo_level);
    endtask

    // One clock: sample on the falling edge and log dout transitions.
    task automatic tick();
        @(negedge clk);
        smp++;
        if (dout && !dout_prev) begin
            if (first_rise < 0) first_rise = smp;
            else per_q.push_back(smp - last_rise);
            last_rise = smp;
        end
        if (!dout && dout_prev) hi_q.push_back(smp - last_rise);
        if (frame_done) begin
            fd_cnt++;
            if (fd_at < 0) fd_at = smp;
            fd_from_rise = smp - last_rise;
        end
        if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
        dout_prev = dout;
    endtask

    task automatic push_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            bus_if.data_in    = bytes[i];
            bus_if.data_valid = 1'b1;
            tick();
        end
        bus_if.data_valid = 1'b0;
        bus_if.data_in    = 8'h00;
    endtask

    task automatic wait_frame(input string tag, input int target, input int limit);
        int g = 0;
        while (fd_cnt < target && g < limit) begin
            tick();
            g++;
        end
        chk({tag, "_frame_seen"}, int'(fd_cnt >= target), 1);
        repeat (3) tick();
        chk({tag, "_frame_pulses"}, fd_cnt, target);
    endtask

    // Expected high time per bit comes straight from the byte values.
    task automatic check_bits(input string tag, input logic [7:0] bytes[$]);
        int nb = 8 * bytes.size();
        logic [7:0] b;
        chk({tag, "_nbits"}, hi_q.size(), nb);
        chk({tag, "_nper"}, per_q.size(), nb - 1);
        for (int i = 0; i < nb; i++) begin
            b = bytes[i / 8];
            chk($sformatf("%s_hi%0d", tag, i),
                (i < hi_q.size()) ? hi_q[i] : -1,
                b[7 - (i % 8)] ? T1H : T0H);
            if (i < nb - 1)
                chk($sformatf("%s_per%0d", tag, i),
                    (i < per_q.size()) ? per_q[i] : -1, TBIT);
        end
    endtask

    logic [7:0] v[$];
    int         g;
    int         lvl_off;

    initial begin
        reset             = 1'b1;
        bus_if.data_in    = 8'h00;
        bus_if.data_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_dout", int'(dout), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 1);

        // Power-up latch: frame_done after exactly TRESET edges, no highs.
        reset = 1'b0;
        arm();
        wait_frame("boot", 1, TRESET + 100);
        chk("boot_fd_at", fd_at, TRESET);
        chk("boot_no_rise", first_rise, -1);
        chk("boot_busy", int'(busy), 0);

        // Single byte 0xA5: strobe sampled at smp 1, rise two clocks later.
        // From the last bit's rise: TBIT cycles of bit, then the latch
        // counter's TRESET edges with frame_done on the last one.
        arm();
        v = '{8'hA5};
        push_seq(v);
        wait_frame("a5", 1, 8 * TBIT + TRESET + 100);
        chk("a5_first_rise", first_rise, 3);
        check_bits("a5", v);
        chk("a5_latch", fd_from_rise, TBIT + TRESET - 1);
        chk("a5_busy", int'(busy), 0);

        // Three bytes on consecutive cycles: contiguous 24-bit stream.
        arm();
        v = '{8'hFF, 8'h00, 8'h80};
        push_seq(v);
        wait_frame("b3", 1, 24 * TBIT + TRESET + 100);
        chk("b3_first_rise", first_rise, 3);
        chk("b3_lvl_peak", lvl_max, 2);
        check_bits("b3", v);
        chk("b3_latch", fd_from_rise, TBIT + TRESET - 1);

        // Twenty bytes back-to-back: first is popped early, 16 stored,
        // the remaining three dropped.
        arm();
        v.delete();
        for (int i = 0; i < 20; i++) v.push_back(8'(i * 37 + 5));
        push_seq(v);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_level", int'(fifo_level), DEPTH);
        wait_frame("ovf", 1, 17 * 8 * TBIT + TRESET + 100);
        chk("ovf_lvl_peak", lvl_max, DEPTH);
        v = v[0:16];
        check_bits("ovf", v);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of the second byte with five still queued.
        arm();
        v = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
        push_seq(v);
        g = 0;
        while (hi_q.size() < 11 && g < 12 * TBIT) begin
            tick();
            g++;
        end
        chk("mid_reached", int'(hi_q.size() >= 11), 1);
        repeat (45) tick();
        chk("mid_level", int'(fifo_level), 5);
        chk("mid_ovf_before", int'(overflow), 1);
        reset = 1'b1;
        tick();
        chk("mid_dout", int'(dout), 0);
        chk("mid_level_rst", int'(fifo_level), 0);
        chk("mid_ovf_rst", int'(overflow), 0);
        reset = 1'b0;

        // Byte pushed while the latch counter is at 100 waits for the latch.
        arm();
        repeat (100) tick();
        v = '{8'h01};
        push_seq(v);
        lvl_off = 0;
        g = 0;
        while (fd_cnt < 1 && g < TRESET + 100) begin
            tick();
            g++;
            if (fifo_level != 5'd1) lvl_off++;
        end
        chk("hold_frame_seen", fd_cnt, 1);
        chk("hold_fd_at", fd_at, TRESET);
        chk("hold_level_off", lvl_off, 0);
        chk("hold_no_early_rise", first_rise, -1);
        wait_frame("hold", 2, 8 * TBIT + TRESET + 100);
        chk("hold_first_rise", first_rise, TRESET + 2);
        check_bits("hold", v);
        chk("hold_latch", fd_from_rise, TBIT + TRESET - 1);
        chk("hold_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
